wordle_score_ctrl: RTL and testbench
====================================

WORDLE_SCORE_CTRL -- requirements
Module: wordle_score_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Port Clk, input, 1 bit: system clock; all state changes on its rising edge.
REQ-003 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port Start, input, 1 bit: request to score one guess; sampled only in IDLE.
REQ-005 Port guess, input, 40 bits: five 8-bit ASCII letters; letter 0 is bits [39:32], letter 4 is bits [7:0].
REQ-006 Port answer, input, 40 bits: hidden word, same packing as guess.
REQ-007 Port busy, output, 1 bit: high in every state except IDLE.
REQ-008 Port done, output, 1 bit: one-cycle pulse; when high, result and win are final.
REQ-009 Port result, output, 10 bits: per-letter score, 2 bits per letter; letter i occupies bits [9-2i:8-2i].
REQ-010 Port win, output, 1 bit: high when result equals 10'h2AA (all five letters green).

Function
REQ-011 Score encoding SHALL be 00 grey, 01 yellow, 10 green; the code 11 SHALL never be produced.
REQ-012 The state machine SHALL have four states: IDLE, GREEN, YELLOW, DONE.
REQ-013 IDLE with Start=1 at a clock edge SHALL:
  - latch guess and answer internally;
  - clear result to 0 and the 5-bit used mask to 0;
  - set the letter index idx to 0;
  - move to GREEN.
REQ-014 Start SHALL be ignored in every state except IDLE; inputs changing after the latch edge SHALL have no effect.
REQ-015 GREEN SHALL process one index per cycle, idx 0 to 4: if guess[idx] equals answer[idx], set result[idx]=10 and used[idx]=1.
REQ-016 After the idx=4 edge, GREEN SHALL move to YELLOW with idx=0.
REQ-017 YELLOW SHALL process one index per cycle:
  - if result[idx] is 10, make no change;
  - otherwise, find the lowest j (0..4) with used[j]=0 and answer[j]==guess[idx];
  - if such a j exists, set result[idx]=01 and used[j]=1; if none exists, leave the letter grey.
REQ-018 The used mask update in one YELLOW cycle SHALL be visible to the next index's search.
REQ-019 After the idx=4 edge, YELLOW SHALL move to DONE; DONE SHALL last exactly one cycle with done=1 and then return to IDLE.
REQ-020 Latency SHALL be fixed: done is high during the 11th cycle after the Start-sampling edge (5 GREEN + 5 YELLOW + 1 DONE).
REQ-021 Comparison SHALL be an exact 8-bit equality with no case folding; any byte values, including non-letters, are scored the same way.
REQ-022 result and win SHALL hold their values after DONE until the next accepted Start, which clears them.
REQ-023 win SHALL be derived from the registered result only, so it is 0 throughout GREEN and YELLOW.

Reset
REQ-024 Asynchronous reset SHALL force state IDLE, busy=0, done=0, result=0, win=0, idx=0, used=0, and clear the latched words.
REQ-025 Reset asserted mid-operation SHALL abort the scoring with no done pulse; the first Start after reset release SHALL be accepted normally.

Verification
REQ-026 guess "ROBOT", answer "ROBOT" -> result 10'h2AA, win=1, done high exactly 11 cycles after Start, busy=1 for cycles 1-11.
REQ-027 guess "ROBIN", answer "ROBOT" -> result 10'h2A0 (G G G grey grey), win=0.
REQ-028 Duplicate handling, guess "ABBOT", answer "BANAL" -> result 10'h140 (Y Y grey grey grey); the second B is grey.
REQ-029 Green priority over yellow, guess "ONION", answer "ROBIN" -> result 10'h112 (Y grey Y grey G); N(1) is grey because answer N(4) was consumed by the green.
REQ-030 Start re-pulsed during YELLOW with a different guess -> ignored; the original result is delivered on schedule and only one done pulse occurs.
REQ-031 reset pulsed during GREEN (idx=2) -> busy=0, result=0, no done pulse; a following Start with "CACAO"/"CACAO" -> 10'h2AA after 11 cycles.

Source files
------------

// File: rtl/wordle_score_ctrl_if.sv
// Handshake and data bundle between a requester and wordle_score_ctrl.
// The master drives the guess/answer request; the slave returns the score.
interface wordle_score_ctrl_if;
    logic        Start;
    logic [39:0] guess;
    logic [39:0] answer;
    logic        busy;
    logic        done;
    logic [9:0]  result;
    logic        win;

    modport master (
        output Start, guess, answer,
        input  busy, done, result, win
    );

    modport slave (
        input  Start, guess, answer,
        output busy, done, result, win
    );
endinterface

// File: rtl/wordle_score_ctrl.sv
// Sequential Wordle scorer: five green-pass cycles, then five yellow-pass cycles,
// then a one-cycle done pulse.
//
// state  | meaning
// IDLE   | waiting for Start; result/win hold the last score
// GREEN  | exact-position match for letter idx, one letter per cycle
// YELLOW | lowest unused answer letter match for letter idx
// DONE   | done pulse; result and win are final
module wordle_score_ctrl (
    input  logic                 Clk,
    input  logic                 reset,
    wordle_score_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, GREEN, YELLOW, DONE} state_t;

    state_t      state;
    logic [2:0]  idx;
    logic [4:0]  used_q;
    logic [39:0] guess_q;
    logic [39:0] answer_q;
    logic [9:0]  result_q;
    logic        busy_q;
    logic        done_q;
    logic        win_q;

    logic [7:0]  cur_guess;
    logic [7:0]  cur_answer;
    logic [1:0]  cur_score;
    logic        hit;
    logic [2:0]  hit_j;
    logic [9:0]  result_green;
    logic [4:0]  used_green;
    logic [9:0]  result_yellow;
    logic [4:0]  used_yellow;

    function automatic logic [7:0] byte_at(input logic [39:0] w, input logic [2:0] i);
        case (i)
            3'd0:    return w[39:32];
            3'd1:    return w[31:24];
            3'd2:    return w[23:16];
            3'd3:    return w[15:8];
            default: return w[7:0];
        endcase
    endfunction

    function automatic logic [1:0] score_at(input logic [9:0] r, input logic [2:0] i);
        case (i)
            3'd0:    return r[9:8];
            3'd1:    return r[7:6];
            3'd2:    return r[5:4];
            3'd3:    return r[3:2];
            default: return r[1:0];
        endcase
    endfunction

    always_comb begin
        cur_guess     = byte_at(guess_q, idx);
        cur_answer    = byte_at(answer_q, idx);
        cur_score     = score_at(result_q, idx);
        hit           = 1'b0;
        hit_j         = 3'd0;
        result_green  = result_q;
        used_green    = used_q;
        result_yellow = result_q;
        used_yellow   = used_q;

        // Scan downwards so the lowest matching unused position wins.
        for (int j = 4; j >= 0; j--) begin
            if (!used_q[j] && byte_at(answer_q, 3'(j)) == cur_guess) begin
                hit   = 1'b1;
                hit_j = 3'(j);
            end
        end

        for (int i = 0; i < 5; i++) begin
            if (idx == 3'(i)) begin
                if (cur_guess == cur_answer) begin
                    result_green[9-2*i -: 2] = 2'b10;
                    used_green[i]            = 1'b1;
                end
                if (cur_score != 2'b10 && hit) begin
                    result_yellow[9-2*i -: 2] = 2'b01;
                    used_yellow[hit_j]        = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= 3'd0;
            used_q   <= 5'd0;
            guess_q  <= 40'd0;
            answer_q <= 40'd0;
            result_q <= 10'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            win_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    if (bus.Start) begin
                        guess_q  <= bus.guess;
                        answer_q <= bus.answer;
                        result_q <= 10'd0;
                        used_q   <= 5'd0;
                        idx      <= 3'd0;
                        win_q    <= 1'b0;
                        busy_q   <= 1'b1;
                        state    <= GREEN;
                    end
                end
                GREEN: begin
                    result_q <= result_green;
                    used_q   <= used_green;
                    if (idx == 3'd4) begin
                        idx   <= 3'd0;
                        state <= YELLOW;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                YELLOW: begin
                    result_q <= result_yellow;
                    used_q   <= used_yellow;
                    if (idx == 3'd4) begin
                        idx    <= 3'd0;
                        done_q <= 1'b1;
                        // Yellow writes only 01, so all-green is already settled here.
                        win_q  <= (result_q == 10'h2AA);
                        state  <= DONE;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.win    = win_q;
endmodule

// File: tb/tb_wordle_score_ctrl.sv
// Directed bench for wordle_score_ctrl: hand-computed scores, cycle-exact
// busy/done/win timing, Start re-pulse immunity and mid-run reset.
module tb_wordle_score_ctrl;
    logic clk_sys = 1'b0;
    logic rst     = 1'b1;
    int   checks  = 0;
    int   errors  = 0;

    always #5 clk_sys = ~clk_sys;

    wordle_score_ctrl_if bus();

    wordle_score_ctrl dut (
        .Clk   (clk_sys),
        .reset (rst),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start is applied at a negedge so the following posedge is the latch edge;
    // cycle n is the low phase after the n-th edge following it.
    task automatic score_word(input string name, input logic [39:0] g, input logic [39:0] a,
                              input logic [9:0] exp_res, input logic exp_win, input bit repulse);
        int done_cnt;
        done_cnt = 0;
        @(negedge clk_sys);
        bus.Start  = 1'b1;
        bus.guess  = g;
        bus.answer = a;
        @(negedge clk_sys);
        bus.Start  = 1'b0;
        bus.guess  = ~g;
        bus.answer = ~a;
        for (int cyc = 1; cyc <= 11; cyc++) begin
            chk({name, " busy"}, bus.busy, 1'b1);
            chk({name, " done"}, bus.done, (cyc == 11));
            chk({name, " win"}, bus.win, (cyc == 11) ? exp_win : 1'b0);
            if (bus.done) done_cnt++;
            if (repulse && cyc == 7) begin
                bus.Start  = 1'b1;
                bus.guess  = "ZZZZZ";
                bus.answer = "QQQQQ";
            end
            if (repulse && cyc == 8) bus.Start = 1'b0;
            @(negedge clk_sys);
        end
        chk({name, " result"}, bus.result, exp_res);
        for (int k = 0; k < 3; k++) begin
            chk({name, " idle busy"}, bus.busy, 1'b0);
            chk({name, " held result"}, bus.result, exp_res);
            chk({name, " held win"}, bus.win, exp_win);
            if (bus.done) done_cnt++;
            @(negedge clk_sys);
        end
        chk({name, " done pulses"}, done_cnt, 1);
    endtask

    initial begin
        int done_cnt;
        bus.Start  = 1'b0;
        bus.guess  = 40'd0;
        bus.answer = 40'd0;
        repeat (2) @(negedge clk_sys);
        chk("reset busy", bus.busy, 1'b0);
        chk("reset done", bus.done, 1'b0);
        chk("reset result", bus.result, 10'h000);
        chk("reset win", bus.win, 1'b0);
        rst = 1'b0;

        score_word("robot",  "ROBOT", "ROBOT", 10'h2AA, 1'b1, 1'b0);
        score_word("robin",  "ROBIN", "ROBOT", 10'h2A0, 1'b0, 1'b0);
        score_word("abbot",  "ABBOT", "BANAL", 10'h140, 1'b0, 1'b0);
        score_word("onion",  "ONION", "ROBIN", 10'h112, 1'b0, 1'b0);
        score_word("repulse", "ONION", "ROBIN", 10'h112, 1'b0, 1'b1);
        score_word("case",   "robot", "ROBOT", 10'h000, 1'b0, 1'b0);
        score_word("nul",    40'h00_00_00_00_00, 40'h00_00_00_00_00, 10'h2AA, 1'b1, 1'b0);
        score_word("shift",  "ABCDE", "EABCD", 10'h155, 1'b0, 1'b0);

        // Abort during GREEN at idx=2.
        @(negedge clk_sys);
        bus.Start  = 1'b1;
        bus.guess  = "ROBOT";
        bus.answer = "ROBOT";
        @(negedge clk_sys);
        bus.Start = 1'b0;
        repeat (2) @(negedge clk_sys);
        chk("pre-reset result", bus.result, 10'h280);
        chk("pre-reset busy", bus.busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("abort busy", bus.busy, 1'b0);
        chk("abort result", bus.result, 10'h000);
        chk("abort done", bus.done, 1'b0);
        chk("abort win", bus.win, 1'b0);
        @(negedge clk_sys);
        rst = 1'b0;
        done_cnt = 0;
        repeat (13) begin
            if (bus.done) done_cnt++;
            @(negedge clk_sys);
        end
        chk("abort no done", done_cnt, 0);
        chk("abort idle", bus.busy, 1'b0);

        score_word("cacao", "CACAO", "CACAO", 10'h2AA, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
